beep_sequencer: RTL

BEEP_SEQUENCER -- requirements
Module: beep_sequencer

---
 rtl/beep_sequencer_if.sv | 32 +++
 rtl/beep_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/beep_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : beep_sequencer_if
//  Description : Request/status bundle between an event source and the
//                beep sequencer. The master raises requests; the slave
//                (sequencer) reports busy, the speaker drive and completion.
//  Revision    : 1.0  initial release
// ============================================================================
interface beep_sequencer_if;
    logic       req;    // event request strobe
    logic [1:0] code;   // 0 none, 1 life gained, 2 life lost, 3 game over
    logic       busy;   // pattern in progress
    logic       beep;   // speaker square wave
    logic       done;   // one-clock completion pulse

    modport master (
        output req,
        output code,
        input  busy,
        input  beep,
        input  done
    );

    modport slave (
        input  req,
        input  code,
        output busy,
        output beep,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/beep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : beep_sequencer
//  Description : Plays short speaker patterns for game events: a single beep,
//                a double beep (beep-gap-beep) or a continuous tone that only
//                clear can stop. Slot length and tone half-period are
//                parameters (both must be at least 1).
//  Revision    : 1.0  initial release
// ============================================================================
module beep_sequencer #(
    parameter int TONE_HALF  = 25000,
    parameter int SLOT_TICKS = 6250000
) (
    input  wire logic        CLK,
    input  wire logic        clear,
    beep_sequencer_if.slave  bus
);

    // Counter widths carry one spare bit so the terminal count never
    // sits at the top of the range.
    localparam int c_tone_w = $clog2(TONE_HALF) + 1;
    localparam int c_slot_w = $clog2(SLOT_TICKS) + 1;

    localparam logic [c_tone_w-1:0] c_tone_last = c_tone_w'(TONE_HALF - 1);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SLOT_TICKS - 1);
    localparam logic [c_tone_w-1:0] c_tone_one  = c_tone_w'(1);
    localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ON1  = 3'd1,
        ST_GAP  = 3'd2,
        ST_ON2  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t              state_q,  state_d;
    logic                double_q, double_d;
    logic [c_slot_w-1:0] slot_q,   slot_d;
    logic [c_tone_w-1:0] tone_q,   tone_d;
    logic                beep_q,   beep_d;
    logic                done_q,   done_d;

    logic w_slot_end;
    logic w_tone_end;
    logic w_req_pattern;
    logic w_req_hold;

    assign w_slot_end    = (slot_q == c_slot_last);
    assign w_tone_end    = (tone_q == c_tone_last);
    assign w_req_pattern = bus.req && ((bus.code == 2'd1) || (bus.code == 2'd2));
    assign w_req_hold    = bus.req && (bus.code == 2'd3);

    // Next-state, counter and output decode; every entry into a sounding
    // state starts with beep high and a fresh tone phase.
    always_comb begin
        state_d  = state_q;
        double_d = double_q;
        slot_d   = slot_q;
        tone_d   = tone_q;
        beep_d   = beep_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                tone_d = '0;
                beep_d = 1'b0;
                if (w_req_pattern) begin
                    state_d  = ST_ON1;
                    double_d = (bus.code == 2'd2);
                    beep_d   = 1'b1;
                end else if (w_req_hold) begin
                    state_d  = ST_HOLD;
                    double_d = 1'b0;
                    beep_d   = 1'b1;
                end
            end

            ST_ON1, ST_ON2: begin
                if (w_tone_end) begin
                    tone_d = '0;
                    beep_d = ~beep_q;
                end else begin
                    tone_d = tone_q + c_tone_one;
                end
                if (w_slot_end) begin
                    slot_d = '0;
                    tone_d = '0;
                    beep_d = 1'b0;
                    if (state_q == ST_ON1 && double_q) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d  = ST_IDLE;
                        double_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end else begin
                    slot_d = slot_q + c_slot_one;
                end
            end

            ST_GAP: begin
                tone_d = '0;
                beep_d = 1'b0;
                if (w_slot_end) begin
                    slot_d  = '0;
                    state_d = ST_ON2;
                    beep_d  = 1'b1;
                end else begin
                    slot_d = slot_q + c_slot_one;
                end
            end

            ST_HOLD: begin
                slot_d = '0;
                if (w_tone_end) begin
                    tone_d = '0;
                    beep_d = ~beep_q;
                end else begin
                    tone_d = tone_q + c_tone_one;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                double_d = 1'b0;
                slot_d   = '0;
                tone_d   = '0;
                beep_d   = 1'b0;
            end
        endcase

        // Game over preempts any finite pattern, including one that is
        // finishing this cycle, so no completion pulse escapes.
        if ((state_q == ST_ON1 || state_q == ST_GAP || state_q == ST_ON2) && w_req_hold) begin
            state_d  = ST_HOLD;
            double_d = 1'b0;
            slot_d   = '0;
            tone_d   = '0;
            beep_d   = 1'b1;
            done_d   = 1'b0;
        end
    end

    // State and counter registers; clear wins over any request.
    always_ff @(posedge CLK) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            double_q <= 1'b0;
            slot_q   <= '0;
            tone_q   <= '0;
            beep_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            double_q <= double_d;
            slot_q   <= slot_d;
            tone_q   <= tone_d;
            beep_q   <= beep_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.beep = beep_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire
